// File: rtl/dmx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_pkg
//  Description : Shared DMX512 receiver timing constants and state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmx_pkg;

  // 250 kbaud bit time and 88 us break, both at a 48 MHz system clock
  localparam int c_DMX_CLOCKS_PER_BIT = 192;
  localparam int c_DMX_BREAK_CLOCKS   = 4224;

  // Number of data slots that follow the start code in a full universe
  localparam logic [9:0] c_DMX_SLOTS = 10'd512;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_BREAK      = 4'd1,
    ST_MAB        = 4'd2,
    ST_WAIT_START = 4'd3,
    ST_START_BIT  = 4'd4,
    ST_DATA       = 4'd5,
    ST_STOP1      = 4'd6,
    ST_STOP2      = 4'd7,
    ST_SKIP       = 4'd8
  } dmx_state_t;

endpackage
`default_nettype wire

// File: rtl/dmx_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_uart_rx
//  Description : DMX line front end: 2-flop synchronizer, falling-edge detect,
//                mid-bit sample timer and LSB-first byte shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmx_uart_rx #(
  parameter int CLOCKS_PER_BIT = dmx_pkg::c_DMX_CLOCKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_async,
  input  logic       i_timer_start,
  input  logic       i_shift,
  output logic       o_rx,
  output logic       o_fall,
  output logic       o_tick,
  output logic [7:0] o_byte
);
  import dmx_pkg::*;

  localparam int c_TW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [c_TW-1:0] c_HALF_M1 = c_TW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [c_TW-1:0] c_FULL_M1 = c_TW'(CLOCKS_PER_BIT - 1);

  logic [1:0]      r_sync;
  logic            r_rx_prev;
  logic [c_TW-1:0] r_timer;
  logic [7:0]      r_shift;

  // Resynchronise the asynchronous line; idle level is high
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync    <= 2'b11;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync    <= {r_sync[0], i_rx_async};
      r_rx_prev <= r_sync[1];
    end
  end

  // Bit timer: first expiry half a bit after the start edge, then every bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_timer <= '0;
    end else if (i_timer_start) begin
      r_timer <= c_HALF_M1;
    end else if (r_timer == '0) begin
      r_timer <= c_FULL_M1;
    end else begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // Shift sampled data bits in from the top so the first bit ends up in [0]
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_shift <= '0;
    end else if (i_shift) begin
      r_shift <= {r_sync[1], r_shift[7:1]};
    end
  end

  assign o_rx   = r_sync[1];
  assign o_fall = r_rx_prev & ~r_sync[1];
  assign o_tick = (r_timer == '0);
  assign o_byte = r_shift;

endmodule
`default_nettype wire

// File: rtl/dmx_in.sv
`default_nettype none
// ============================================================================
//  Module      : dmx_in
//  Description : DMX512 receiver. Detects breaks, frames slots, packs data
//                slot pairs into 16-bit words and writes them to an SRAM bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmx_in #(
  parameter int ADDRESS_BUS_WIDTH = 14,
  parameter int START_ADDRESS     = 0,
  parameter int CLOCKS_PER_BIT    = dmx_pkg::c_DMX_CLOCKS_PER_BIT,
  parameter int BREAK_CLOCKS      = dmx_pkg::c_DMX_BREAK_CLOCKS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dmx_rx,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [15:0]                  write_data,
  output logic                         write_strobe,
  output logic                         frame_done_strobe,
  output logic                         frame_error
);
  import dmx_pkg::*;

  localparam int c_LOW_W = $clog2(BREAK_CLOCKS + 1);
  localparam logic [c_LOW_W-1:0] c_BREAK_CNT = c_LOW_W'(BREAK_CLOCKS);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] c_BASE = ADDRESS_BUS_WIDTH'(START_ADDRESS);

  dmx_state_t r_state, w_state_next;

  logic               w_rx, w_fall, w_tick;
  logic [7:0]         w_byte;
  logic               w_timer_start, w_shift, w_byte_done, w_stop_err;
  logic               w_break_hit, w_break_start;
  logic               w_pair_wr, w_flush_wr, w_last_wr, w_done_set, w_wr_now;
  logic [15:0]        w_wr_data;

  logic [c_LOW_W-1:0] r_low_cnt;
  logic [2:0]         r_bit;
  logic               r_in_frame;
  logic [9:0]         r_data_cnt;
  logic [7:0]         r_pair;
  logic [7:0]         r_pending;
  logic               r_done_req;
  logic                         r_write_strobe;
  logic                         r_frame_done;
  logic                         r_frame_error;
  logic [ADDRESS_BUS_WIDTH-1:0] r_write_address;
  logic [15:0]                  r_write_data;

  dmx_uart_rx #(
    .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
  ) u_uart (
    .clk           (clk),
    .rst           (rst),
    .i_rx_async    (dmx_rx),
    .i_timer_start (w_timer_start),
    .i_shift       (w_shift),
    .o_rx          (w_rx),
    .o_fall        (w_fall),
    .o_tick        (w_tick),
    .o_byte        (w_byte)
  );

  // Count consecutive low samples, saturating at the break length
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_low_cnt <= '0;
    end else if (w_rx) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != c_BREAK_CNT) begin
      r_low_cnt <= r_low_cnt + 1'b1;
    end
  end

  assign w_break_hit   = (r_low_cnt == c_BREAK_CNT);
  assign w_break_start = w_break_hit && (r_state != ST_BREAK);

  // State register and data-bit counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_bit   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_timer_start) begin
        r_bit <= '0;
      end else if (w_shift) begin
        r_bit <= r_bit + 1'b1;
      end
    end
  end

  // Slot framing; a qualified break overrides whatever slot is in progress
  always_comb begin
    w_state_next  = r_state;
    w_timer_start = 1'b0;
    w_shift       = 1'b0;
    w_byte_done   = 1'b0;
    w_stop_err    = 1'b0;
    unique case (r_state)
      ST_IDLE: ;
      ST_BREAK: if (w_rx) w_state_next = ST_MAB;
      ST_MAB: w_state_next = ST_WAIT_START;
      ST_WAIT_START: begin
        if (w_fall) begin
          w_timer_start = 1'b1;
          w_state_next  = ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (w_tick) w_state_next = w_rx ? ST_WAIT_START : ST_DATA;
      end
      ST_DATA: begin
        if (w_tick) begin
          w_shift = 1'b1;
          if (r_bit == 3'd7) w_state_next = ST_STOP1;
        end
      end
      ST_STOP1: begin
        if (w_tick) begin
          if (w_rx) begin
            w_state_next = ST_STOP2;
          end else begin
            w_stop_err   = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_STOP2: begin
        if (w_tick) begin
          if (w_rx) begin
            w_byte_done  = 1'b1;
            w_state_next = (!r_in_frame && (w_byte != 8'h00)) ? ST_SKIP : ST_WAIT_START;
          end else begin
            w_stop_err   = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_SKIP: ;
      default: w_state_next = ST_IDLE;
    endcase
    if (w_break_hit) begin
      w_state_next  = ST_BREAK;
      w_timer_start = 1'b0;
      w_shift       = 1'b0;
      w_byte_done   = 1'b0;
      w_stop_err    = 1'b0;
    end
  end

  // Write/done requests: completed pairs, the 512th slot, and break-time flush
  assign w_pair_wr  = w_byte_done && r_in_frame && (r_data_cnt != c_DMX_SLOTS) && r_data_cnt[0];
  assign w_last_wr  = w_pair_wr && (r_data_cnt == c_DMX_SLOTS - 10'd1);
  assign w_flush_wr = w_break_start && r_in_frame && r_data_cnt[0];
  assign w_done_set = w_last_wr || w_flush_wr ||
                      (w_break_start && r_in_frame && !r_data_cnt[0] &&
                       (r_data_cnt >= 10'd2) && (r_data_cnt != c_DMX_SLOTS));
  assign w_wr_now   = w_pair_wr || w_flush_wr;
  assign w_wr_data  = w_pair_wr ? {r_pending, w_byte} : {r_pending, 8'h00};

  // Track start code acceptance, data slot count and the odd slot awaiting its partner
  always_ff @(posedge clk) begin
    if (!rst || w_break_start) begin
      r_in_frame <= 1'b0;
      r_data_cnt <= '0;
      r_pair     <= '0;
      r_pending  <= '0;
    end else if (w_byte_done) begin
      if (!r_in_frame) begin
        r_in_frame <= (w_byte == 8'h00);
      end else if (r_data_cnt != c_DMX_SLOTS) begin
        r_data_cnt <= r_data_cnt + 1'b1;
        if (!r_data_cnt[0]) r_pending <= w_byte;
        else                r_pair    <= r_pair + 1'b1;
      end
    end
  end

  // Output stage; a frame-done request waits for any write in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write_strobe  <= 1'b0;
      r_frame_done    <= 1'b0;
      r_done_req      <= 1'b0;
      r_write_address <= c_BASE;
      r_write_data    <= '0;
    end else begin
      r_write_strobe <= 1'b0;
      r_frame_done   <= 1'b0;
      if (w_wr_now) begin
        r_write_strobe  <= 1'b1;
        r_write_address <= c_BASE + ADDRESS_BUS_WIDTH'(r_pair);
        r_write_data    <= w_wr_data;
      end else if (r_done_req) begin
        r_frame_done <= 1'b1;
        r_done_req   <= 1'b0;
      end
      if (w_done_set) r_done_req <= 1'b1;
    end
  end

  // Sticky framing error, cleared when the next break qualifies
  always_ff @(posedge clk) begin
    if (!rst || w_break_start) begin
      r_frame_error <= 1'b0;
    end else if (w_stop_err) begin
      r_frame_error <= 1'b1;
    end
  end

  assign write_address     = r_write_address;
  assign write_data        = r_write_data;
  assign write_strobe      = r_write_strobe;
  assign frame_done_strobe = r_frame_done;
  assign frame_error       = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_dmx_in.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmx_in
//  Description : Self-checking bench for dmx_in with a scaled bit time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmx_in;

  localparam int AW        = 14;
  localparam int SA        = 256;
  localparam int CPB       = 8;
  localparam int BRK       = 176;   // 88 us at 4 us per bit
  localparam int BREAK_LEN = 200;   // 100 us
  localparam int SHORT_LEN = 160;   // 80 us
  localparam int MAB_LEN   = 24;    // 12 us

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          dmx_rx = 1'b1;
  logic [AW-1:0] write_address;
  logic [15:0]   write_data;
  logic          write_strobe;
  logic          frame_done_strobe;
  logic          frame_error;

  dmx_in #(
    .ADDRESS_BUS_WIDTH (AW),
    .START_ADDRESS     (SA),
    .CLOCKS_PER_BIT    (CPB),
    .BREAK_CLOCKS      (BRK)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .dmx_rx            (dmx_rx),
    .write_address     (write_address),
    .write_data        (write_data),
    .write_strobe      (write_strobe),
    .frame_done_strobe (frame_done_strobe),
    .frame_error       (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_done;
    bit            after_wr;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } exp_t;

  typedef struct {
    logic [7:0] sc;
    int         n;
    logic [7:0] first;
    logic [7:0] step;
    int         exp_wr;
    int         exp_done;
  } vec_t;

  exp_t       sb[$];
  logic [7:0] slots[$];
  vec_t       tbl[6];
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_wr     = 0;
  int         n_done   = 0;
  bit         prev_wr  = 1'b0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_wr(input int k, input logic [15:0] d);
    exp_t e;
    e.is_done = 1'b0; e.after_wr = 1'b0; e.addr = AW'(SA + k); e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_done(input bit aw);
    exp_t e;
    e.is_done = 1'b1; e.after_wr = aw; e.addr = '0; e.data = '0;
    sb.push_back(e);
  endtask

  // Expected bus traffic for a frame with start code 0 and the slots queue
  task automatic model_frame();
    int n;
    n = (slots.size() > 512) ? 512 : slots.size();
    for (int i = 0; i < n; i += 2)
      push_wr(i / 2, (i + 1 < n) ? {slots[i], slots[i+1]} : {slots[i], 8'h00});
    if (n > 0) push_done((n % 2 == 1) || (n == 512));
  endtask

  task automatic hold(input logic v, input int n);
    dmx_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, 2 * CPB);
  endtask

  task automatic send_body(input logic [7:0] sc);
    hold(1'b0, BREAK_LEN);
    hold(1'b1, MAB_LEN);
    send_byte(sc, 1'b1);
    foreach (slots[i]) send_byte(slots[i], 1'b1);
  endtask

  task automatic end_frame();
    hold(1'b0, BREAK_LEN);
    hold(1'b1, MAB_LEN);
  endtask

  // Scoreboard side: compare every strobe against the head of the queue
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (rst) begin
      if (write_strobe || frame_done_strobe)
        check(!(write_strobe && frame_done_strobe), "strobe_overlap",
              {30'd0, write_strobe, frame_done_strobe}, {30'd0, write_strobe, 1'b0});
      if (write_strobe) begin
        n_wr++;
        ok = (sb.size() != 0) && !sb[0].is_done;
        check(ok, "write_expected", 32'(write_address), 32'(sb.size()));
        if (ok) begin
          e = sb.pop_front();
          check(write_address == e.addr, "write_address", 32'(write_address), 32'(e.addr));
          check(write_data == e.data, "write_data", 32'(write_data), 32'(e.data));
        end
      end
      if (frame_done_strobe) begin
        n_done++;
        ok = (sb.size() != 0) && sb[0].is_done;
        check(ok, "frame_done_expected", 32'd1, 32'(sb.size()));
        if (ok) begin
          e = sb.pop_front();
          if (e.after_wr) check(prev_wr, "done_after_write", 32'(prev_wr), 32'd1);
        end
      end
    end
    prev_wr = write_strobe;
  end

  initial begin
    #(1300000 * 10);
    $display("FAIL watchdog: run exceeded its cycle budget, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h00, 3, 8'h11, 8'h11, 2, 1};
    tbl[1] = '{8'h00, 1, 8'hA5, 8'h01, 1, 1};
    tbl[2] = '{8'h00, 2, 8'h80, 8'h7F, 1, 1};
    tbl[3] = '{8'hCC, 4, 8'h10, 8'h10, 0, 0};
    tbl[4] = '{8'h00, 6, 8'hF0, 8'h03, 3, 1};
    tbl[5] = '{8'h00, 0, 8'h00, 8'h00, 0, 0};

    // Reset values
    repeat (5) @(negedge clk);
    check(write_strobe == 1'b0, "rst_write_strobe", 32'(write_strobe), 32'd0);
    check(frame_done_strobe == 1'b0, "rst_frame_done", 32'(frame_done_strobe), 32'd0);
    check(frame_error == 1'b0, "rst_frame_error", 32'(frame_error), 32'd0);
    check(write_address == AW'(SA), "rst_write_address", 32'(write_address), 32'(SA));
    check(write_data == 16'h0000, "rst_write_data", 32'(write_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 80 us low is not a break: slots after it are ignored
    n_wr = 0; n_done = 0;
    hold(1'b0, SHORT_LEN);
    hold(1'b1, MAB_LEN);
    send_byte(8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    hold(1'b1, 4 * CPB);
    check(n_wr == 0, "short_break_writes", 32'(n_wr), 32'd0);
    check(n_done == 0, "short_break_done", 32'(n_done), 32'd0);
    check(frame_error == 1'b0, "short_break_error", 32'(frame_error), 32'd0);

    // Table of short frames
    for (int t = 0; t < 6; t++) begin
      slots.delete();
      for (int i = 0; i < tbl[t].n; i++) slots.push_back(8'(tbl[t].first + tbl[t].step * i));
      n_wr = 0; n_done = 0;
      if (tbl[t].sc == 8'h00) model_frame();
      send_body(tbl[t].sc);
      end_frame();
      check(sb.size() == 0, $sformatf("tbl%0d_drained", t), 32'(sb.size()), 32'd0);
      check(n_wr == tbl[t].exp_wr, $sformatf("tbl%0d_writes", t), 32'(n_wr), 32'(tbl[t].exp_wr));
      check(n_done == tbl[t].exp_done, $sformatf("tbl%0d_done", t), 32'(n_done), 32'(tbl[t].exp_done));
      check(frame_error == 1'b0, $sformatf("tbl%0d_error_clear", t), 32'(frame_error), 32'd0);
      sb.delete();
    end

    // Full universe plus two extra slots that must be ignored
    slots.delete();
    for (int i = 1; i <= 514; i++) slots.push_back(8'(i));
    n_wr = 0; n_done = 0;
    model_frame();
    send_body(8'h00);
    end_frame();
    check(n_wr == 256, "full_writes", 32'(n_wr), 32'd256);
    check(n_done == 1, "full_done", 32'(n_done), 32'd1);
    check(sb.size() == 0, "full_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // Slot 3 with a low stop bit: sticky error, later slots ignored
    n_wr = 0; n_done = 0;
    push_wr(0, 16'h4142);
    hold(1'b0, BREAK_LEN);
    hold(1'b1, MAB_LEN);
    send_byte(8'h00, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b0);
    hold(1'b1, 2 * CPB);
    check(frame_error == 1'b1, "stop_low_error", 32'(frame_error), 32'd1);
    send_byte(8'h44, 1'b1);
    hold(1'b1, 2 * CPB);
    check(n_wr == 1, "stop_low_writes", 32'(n_wr), 32'd1);
    check(frame_error == 1'b1, "stop_low_sticky", 32'(frame_error), 32'd1);
    push_done(1'b0);
    end_frame();
    check(frame_error == 1'b0, "break_clears_error", 32'(frame_error), 32'd0);
    check(sb.size() == 0, "stop_low_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // 2-clock low glitch between slots is rejected at the start-bit check
    slots.delete();
    for (int i = 1; i <= 4; i++) slots.push_back(8'(8'h20 + i));
    n_wr = 0; n_done = 0;
    model_frame();
    hold(1'b0, BREAK_LEN);
    hold(1'b1, MAB_LEN);
    send_byte(8'h00, 1'b1);
    send_byte(slots[0], 1'b1);
    send_byte(slots[1], 1'b1);
    hold(1'b1, CPB);
    hold(1'b0, 2);
    hold(1'b1, 2 * CPB);
    send_byte(slots[2], 1'b1);
    send_byte(slots[3], 1'b1);
    end_frame();
    check(n_wr == 2, "glitch_writes", 32'(n_wr), 32'd2);
    check(sb.size() == 0, "glitch_drained", 32'(sb.size()), 32'd0);
    sb.delete();

    // Reset between slot 1 and slot 2 discards the pending slot
    slots.delete();
    slots.push_back(8'h55);
    n_wr = 0; n_done = 0;
    send_body(8'h00);
    hold(1'b1, CPB);
    rst = 1'b0;
    hold(1'b1, 4);
    check(write_strobe == 1'b0, "midrst_write_strobe", 32'(write_strobe), 32'd0);
    check(frame_done_strobe == 1'b0, "midrst_frame_done", 32'(frame_done_strobe), 32'd0);
    check(frame_error == 1'b0, "midrst_frame_error", 32'(frame_error), 32'd0);
    check(write_address == AW'(SA), "midrst_write_address", 32'(write_address), 32'(SA));
    check(write_data == 16'h0000, "midrst_write_data", 32'(write_data), 32'd0);
    rst = 1'b1;
    send_byte(8'h66, 1'b1);
    hold(1'b1, 2 * CPB);
    end_frame();
    check(n_wr == 0, "midrst_writes", 32'(n_wr), 32'd0);
    check(n_done == 0, "midrst_done", 32'(n_done), 32'd0);
    slots.delete();
    for (int i = 1; i <= 4; i++) slots.push_back(8'(8'h70 + i));
    model_frame();
    send_body(8'h00);
    end_frame();
    check(n_wr == 2, "after_rst_writes", 32'(n_wr), 32'd2);
    check(n_done == 1, "after_rst_done", 32'(n_done), 32'd1);
    check(sb.size() == 0, "after_rst_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
